// File: rtl/vec_assembler.sv
// Collects SUB_VECTOR_NO bus words into one vector and presents it, together with
// its ID, popcount and batch-last flag, on a valid/ready output.
module vec_assembler #(
  parameter int unsigned VECTOR_WIDTH  = 920,
  parameter int unsigned BUS_WIDTH     = 128,
  parameter int unsigned SUB_VECTOR_NO = (VECTOR_WIDTH + BUS_WIDTH - 1) / BUS_WIDTH,
  parameter int unsigned VEC_ID_WIDTH  = 16,
  parameter int unsigned CNT_WIDTH     = $clog2(VECTOR_WIDTH)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [BUS_WIDTH-1:0]    up_SubVector,
  input  logic [VEC_ID_WIDTH-1:0] up_ID,
  input  logic                    up_Valid,
  input  logic [CNT_WIDTH-1:0]    up_Cnt,
  input  logic                    up_CntNew,
  input  logic                    up_Last,
  output logic                    up_Ready,
  output logic [VECTOR_WIDTH-1:0] dn_Vector,
  output logic [VEC_ID_WIDTH-1:0] dn_ID,
  output logic [CNT_WIDTH-1:0]    dn_Cnt,
  output logic                    dn_Last,
  output logic                    dn_Valid,
  input  logic                    dn_Ready,
  output logic                    err_Framing,
  output logic                    err_IdMismatch
);

  localparam int unsigned IDX_W = (SUB_VECTOR_NO > 1) ? $clog2(SUB_VECTOR_NO) : 1;
  localparam int unsigned ASM_W = (SUB_VECTOR_NO > 1) ? (SUB_VECTOR_NO - 1) * BUS_WIDTH : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(SUB_VECTOR_NO - 1);

  logic [IDX_W-1:0]        idx_q, idx_d;
  logic [ASM_W-1:0]        asm_q, asm_d;
  logic [VEC_ID_WIDTH-1:0] id_q, id_d;
  logic [VECTOR_WIDTH-1:0] dn_vector_q, dn_vector_d;
  logic [VEC_ID_WIDTH-1:0] dn_id_q, dn_id_d;
  logic [CNT_WIDTH-1:0]    dn_cnt_q, dn_cnt_d;
  logic                    dn_last_q, dn_last_d;
  logic                    dn_valid_q, dn_valid_d;
  logic                    err_framing_q, err_framing_d;
  logic                    err_id_q, err_id_d;

  logic                    at_last_c;
  logic                    up_ready_c;
  logic                    accept_c;
  logic [VEC_ID_WIDTH-1:0] word0_id_c;

  // The final slot may only be taken once the output register is free or draining.
  always_comb begin
    at_last_c  = (idx_q == LAST_IDX);
    up_ready_c = !rst && (!at_last_c || !dn_valid_q || dn_Ready);
    accept_c   = up_Valid && up_ready_c;
    word0_id_c = (idx_q == '0) ? up_ID : id_q;
  end

  always_comb begin
    idx_d         = idx_q;
    asm_d         = asm_q;
    id_d          = id_q;
    dn_vector_d   = dn_vector_q;
    dn_id_d       = dn_id_q;
    dn_cnt_d      = dn_cnt_q;
    dn_last_d     = dn_last_q;
    dn_valid_d    = dn_valid_q;
    err_framing_d = err_framing_q;
    err_id_d      = err_id_q;

    if (dn_valid_q && dn_Ready) begin
      dn_valid_d = 1'b0;
    end

    if (accept_c) begin
      if (idx_q == '0) begin
        id_d = up_ID;
      end else if (up_ID != id_q) begin
        err_id_d = 1'b1;
      end

      for (int unsigned k = 0; k + 1 < SUB_VECTOR_NO; k++) begin
        if (idx_q == IDX_W'(k)) begin
          asm_d[k*BUS_WIDTH +: BUS_WIDTH] = up_SubVector;
        end
      end

      if (at_last_c) begin
        idx_d = '0;
        if (up_CntNew) begin
          // Final word sits above the buffered words; bits beyond the vector are dropped.
          if (SUB_VECTOR_NO > 1) begin
            dn_vector_d = VECTOR_WIDTH'({up_SubVector, asm_q});
          end else begin
            dn_vector_d = VECTOR_WIDTH'(up_SubVector);
          end
          dn_id_d    = word0_id_c;
          dn_cnt_d   = up_Cnt;
          dn_last_d  = up_Last;
          dn_valid_d = 1'b1;
        end else begin
          err_framing_d = 1'b1;
        end
      end else if (up_CntNew) begin
        err_framing_d = 1'b1;
        idx_d         = '0;
      end else begin
        idx_d = idx_q + IDX_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      idx_q         <= '0;
      asm_q         <= '0;
      id_q          <= '0;
      dn_vector_q   <= '0;
      dn_id_q       <= '0;
      dn_cnt_q      <= '0;
      dn_last_q     <= 1'b0;
      dn_valid_q    <= 1'b0;
      err_framing_q <= 1'b0;
      err_id_q      <= 1'b0;
    end else begin
      idx_q         <= idx_d;
      asm_q         <= asm_d;
      id_q          <= id_d;
      dn_vector_q   <= dn_vector_d;
      dn_id_q       <= dn_id_d;
      dn_cnt_q      <= dn_cnt_d;
      dn_last_q     <= dn_last_d;
      dn_valid_q    <= dn_valid_d;
      err_framing_q <= err_framing_d;
      err_id_q      <= err_id_d;
    end
  end

  assign up_Ready       = up_ready_c;
  assign dn_Vector      = dn_vector_q;
  assign dn_ID          = dn_id_q;
  assign dn_Cnt         = dn_cnt_q;
  assign dn_Last        = dn_last_q;
  assign dn_Valid       = dn_valid_q;
  assign err_Framing    = err_framing_q;
  assign err_IdMismatch = err_id_q;

endmodule

// File: tb/tb_vec_assembler.sv
// Directed bench for vec_assembler: expected vectors are queued when the final word
// is driven and compared whenever the output handshakes.
module tb_vec_assembler;

  localparam int unsigned VW = 920;
  localparam int unsigned BW = 128;
  localparam int unsigned N  = 8;
  localparam int unsigned IW = 16;
  localparam int unsigned CW = 10;
  localparam int unsigned LW = VW - (N - 1) * BW;

  typedef struct packed {
    logic [VW-1:0] vec;
    logic [IW-1:0] id;
    logic [CW-1:0] cnt;
    logic          last;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst;
  logic [BW-1:0] up_SubVector;
  logic [IW-1:0] up_ID;
  logic          up_Valid;
  logic [CW-1:0] up_Cnt;
  logic          up_CntNew;
  logic          up_Last;
  logic          up_Ready;
  logic [VW-1:0] dn_Vector;
  logic [IW-1:0] dn_ID;
  logic [CW-1:0] dn_Cnt;
  logic          dn_Last;
  logic          dn_Valid;
  logic          dn_Ready;
  logic          err_Framing;
  logic          err_IdMismatch;

  vec_assembler dut (
    .clk(clk), .rst(rst),
    .up_SubVector(up_SubVector), .up_ID(up_ID), .up_Valid(up_Valid),
    .up_Cnt(up_Cnt), .up_CntNew(up_CntNew), .up_Last(up_Last), .up_Ready(up_Ready),
    .dn_Vector(dn_Vector), .dn_ID(dn_ID), .dn_Cnt(dn_Cnt), .dn_Last(dn_Last),
    .dn_Valid(dn_Valid), .dn_Ready(dn_Ready),
    .err_Framing(err_Framing), .err_IdMismatch(err_IdMismatch)
  );

  always #5 clk = ~clk;

  int            n_tests = 0;
  int            n_fail  = 0;
  exp_t          sb[$];
  logic [BW-1:0] w_arr[N];
  logic [IW-1:0] id_arr[N];
  logic          last_acc;
  logic          s_up_ready;
  exp_t          e_a;
  exp_t          e_b;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_vec(input string tag, input logic [VW-1:0] obs, input logic [VW-1:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed[63:0]=%0h expected[63:0]=%0h differing_bits=%0d",
             tag, obs[63:0], exp[63:0], $countones(obs ^ exp));
    end
  endtask

  // One clock: sample handshakes on the falling edge, then step past the rising edge.
  task automatic tick();
    exp_t e;
    @(negedge clk);
    s_up_ready = up_Ready;
    last_acc   = up_Valid && up_Ready;
    if (!rst && dn_Valid && dn_Ready) begin
      n_tests++;
      assert (sb.size() != 0) else begin
        n_fail++;
        $error("FAIL unexpected_output observed_id=%0h expected=none", dn_ID);
      end
      if (sb.size() != 0) begin
        e = sb.pop_front();
        chk_vec("out_vector", dn_Vector, e.vec);
        chk("out_id", 32'(dn_ID), 32'(e.id));
        chk("out_cnt", 32'(dn_Cnt), 32'(e.cnt));
        chk("out_last", 32'(dn_Last), 32'(e.last));
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic send_word(input logic [BW-1:0] d, input logic [IW-1:0] id,
                           input logic cn, input logic [CW-1:0] cnt, input logic lst);
    int guard;
    up_SubVector = d;
    up_ID        = id;
    up_CntNew    = cn;
    up_Cnt       = cnt;
    up_Last      = lst;
    up_Valid     = 1'b1;
    guard        = 0;
    do begin
      tick();
      guard++;
    end while (!last_acc && guard < 50);
    n_tests++;
    assert (last_acc) else begin
      n_fail++;
      $error("FAIL word_accept_timeout observed=stalled expected=accepted");
    end
  endtask

  task automatic send_vec(input int n_words, input int cn_at, input logic [CW-1:0] cnt,
                          input logic lst);
    for (int i = 0; i < n_words; i++) begin
      send_word(w_arr[i], id_arr[i], i == cn_at,
                (i == cn_at) ? cnt : CW'($urandom), lst && (i == n_words - 1));
    end
    up_Valid = 1'b0;
  endtask

  function automatic logic [VW-1:0] build_vec();
    logic [VW-1:0] v;
    logic [BW-1:0] t;
    v = '0;
    for (int k = 0; k < int'(N) - 1; k++) v[k*BW +: BW] = w_arr[k];
    t = w_arr[N-1];
    v[(N-1)*BW +: LW] = t[LW-1:0];
    return v;
  endfunction

  task automatic fill(input int mode, input logic [IW-1:0] id);
    for (int i = 0; i < int'(N); i++) begin
      case (mode)
        0:       w_arr[i] = '1;
        1:       w_arr[i] = {$urandom, $urandom, $urandom, $urandom};
        default: w_arr[i] = (i == int'(N) - 1) ? '1 : '0;
      endcase
      id_arr[i] = id;
    end
  endtask

  initial begin
    rst = 1'b1; up_Valid = 1'b1; up_SubVector = '1; up_ID = 16'd3;
    up_Cnt = '0; up_CntNew = 1'b1; up_Last = 1'b1; dn_Ready = 1'b1;
    last_acc = 1'b0; s_up_ready = 1'b0;

    // Reset held with traffic present.
    @(posedge clk); #1;
    repeat (3) begin
      tick();
      chk("rst_up_ready", 32'(up_Ready), 32'd0);
      chk("rst_dn_valid", 32'(dn_Valid), 32'd0);
    end
    chk_vec("rst_dn_vector", dn_Vector, '0);
    chk("rst_dn_id", 32'(dn_ID), 32'd0);
    chk("rst_dn_cnt", 32'(dn_Cnt), 32'd0);
    chk("rst_dn_last", 32'(dn_Last), 32'd0);
    chk("rst_errs", 32'({err_Framing, err_IdMismatch}), 32'd0);
    rst = 1'b0; up_Valid = 1'b0; up_CntNew = 1'b0; up_Last = 1'b0;
    tick();

    // Single all-ones vector; dn_Valid must be up right after the final handshake.
    fill(0, 16'd5);
    sb.push_back('{vec: build_vec(), id: 16'd5, cnt: CW'(920), last: 1'b0});
    send_vec(N, N - 1, CW'(920), 1'b0);
    chk("latency_dn_valid", 32'(dn_Valid), 32'd1);
    tick();

    // Back-pressure: second vector's final word must stall until the output drains.
    dn_Ready = 1'b0;
    fill(1, 16'd10);
    e_a = '{vec: build_vec(), id: 16'd10, cnt: CW'(300), last: 1'b0};
    sb.push_back(e_a);
    send_vec(N, N - 1, CW'(300), 1'b0);
    fill(1, 16'd11);
    e_b = '{vec: build_vec(), id: 16'd11, cnt: CW'(401), last: 1'b1};
    send_vec(N - 1, -1, '0, 1'b0);
    up_SubVector = w_arr[N-1]; up_ID = 16'd11; up_CntNew = 1'b1;
    up_Cnt = CW'(401); up_Last = 1'b1; up_Valid = 1'b1;
    tick();
    chk("bp_ready_low", 32'(s_up_ready), 32'd0);
    tick();
    chk("bp_still_stalled", 32'(last_acc), 32'd0);
    chk("bp_hold_id", 32'(dn_ID), 32'(e_a.id));
    chk_vec("bp_hold_vector", dn_Vector, e_a.vec);
    dn_Ready = 1'b1;
    sb.push_back(e_b);
    tick();
    chk("bp_same_cycle_load", 32'(last_acc), 32'd1);
    up_Valid = 1'b0; up_CntNew = 1'b0; up_Last = 1'b0; dn_Ready = 1'b0;
    chk("bp_second_valid", 32'(dn_Valid), 32'd1);
    chk("bp_second_id", 32'(dn_ID), 32'(e_b.id));
    dn_Ready = 1'b1;
    tick();

    // Early CntNew on word 3, then a clean vector must assemble from index 0.
    fill(1, 16'd9);
    send_vec(4, 3, CW'(77), 1'b0);
    tick();
    chk("frame_early_err", 32'(err_Framing), 32'd1);
    chk("frame_early_no_out", 32'(dn_Valid), 32'd0);
    fill(1, 16'd9);
    sb.push_back('{vec: build_vec(), id: 16'd9, cnt: CW'(17), last: 1'b0});
    send_vec(N, N - 1, CW'(17), 1'b0);
    tick();
    chk("frame_sticky", 32'(err_Framing), 32'd1);

    // Reset clears the flags; then a final word without CntNew is a framing error.
    rst = 1'b1; tick(); tick(); rst = 1'b0;
    chk("err_cleared", 32'({err_Framing, err_IdMismatch}), 32'd0);
    fill(1, 16'd4);
    send_vec(N, -1, '0, 1'b0);
    tick();
    chk("frame_late_err", 32'(err_Framing), 32'd1);
    chk("frame_late_no_out", 32'(dn_Valid), 32'd0);

    // ID mismatch on word 4: flagged, vector keeps the word-0 ID.
    fill(1, 16'd5);
    id_arr[4] = 16'd6;
    sb.push_back('{vec: build_vec(), id: 16'd5, cnt: CW'(512), last: 1'b0});
    send_vec(N, N - 1, CW'(512), 1'b0);
    chk("id_mismatch_err", 32'(err_IdMismatch), 32'd1);
    tick();

    // Final word truncation with batch-last.
    fill(2, 16'h00A5);
    sb.push_back('{vec: build_vec(), id: 16'h00A5, cnt: CW'(24), last: 1'b1});
    send_vec(N, N - 1, CW'(24), 1'b1);

    for (int i = 0; i < 20 && sb.size() != 0; i++) tick();
    tick();
    chk("scoreboard_drained", 32'(sb.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
